store_buffer: RTL and testbench

//  Posted-write buffer that sits directly downstream of the store formatting logic in the MEM stage.

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/store_buffer.sv | 121 ++++++++++++
 tb/tb_store_buffer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types for the MEM-stage posted-write store buffer.
package store_buffer_pkg;

    localparam int STORE_BUF_DEPTH = 4;

    typedef struct packed {
        logic [29:0] waddr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE     = 2'd0,
        SB_ISSUE    = 2'd1,
        SB_WAIT_ACK = 2'd2
    } sb_state_t;

endpackage

// File: rtl/store_buffer.sv
// In-order posted-write buffer: queues formatted stores, drains them one at a time
// to data memory, flags loads that alias a pending store word, reports write errors.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = STORE_BUF_DEPTH,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ST_VALID,
    input  logic [ADDR_W-1:0] ST_ADDR,
    input  logic [3:0]        ST_WMASK,
    input  logic [31:0]       ST_WDATA,
    output logic              ST_READY,
    input  logic              LD_CHECK_VALID,
    input  logic [ADDR_W-1:0] LD_CHECK_ADDR,
    output logic              LD_HAZARD,
    output logic              DRAINED,
    output logic              DMEM_REQ_VALID,
    input  logic              DMEM_REQ_READY,
    output logic [ADDR_W-1:0] DMEM_REQ_ADDR,
    output logic [3:0]        DMEM_REQ_WMASK,
    output logic [31:0]       DMEM_REQ_WDATA,
    input  logic              DMEM_RESP_VALID,
    input  logic              DMEM_RESP_ERR,
    output logic              STORE_FAULT,
    output logic [ADDR_W-1:0] STORE_FAULT_ADDR
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          ent [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count;
    sb_state_t          state, state_nxt;

    logic               push, pop, issue;
    logic               hz;
    logic [29:0]        ld_waddr;
    logic [29:0]        st_waddr;
    logic               unused_lsbs;

    assign unused_lsbs = ^{ST_ADDR[1:0], LD_CHECK_ADDR[1:0]};

    assign st_waddr = 30'(ST_ADDR[ADDR_W-1:2]);
    assign ld_waddr = 30'(LD_CHECK_ADDR[ADDR_W-1:2]);

    // A zero mask is a suppressed store: handshaken but never queued.
    assign ST_READY = (count != CNT_W'(DEPTH));
    assign push     = ST_VALID & ST_READY & (|ST_WMASK);
    assign pop      = (state == SB_WAIT_ACK) & DMEM_RESP_VALID;
    assign issue    = (state == SB_ISSUE);
    assign DRAINED  = (count == '0) & (state == SB_IDLE);

    // Payload storage needs no reset; vld qualifies every use of it.
    always_ff @(posedge CLK) begin
        if (push)
            ent[tail] <= '{waddr: st_waddr, wmask: ST_WMASK, wdata: ST_WDATA};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vld              <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            state            <= SB_IDLE;
            STORE_FAULT      <= 1'b0;
            STORE_FAULT_ADDR <= '0;
        end else begin
            state       <= state_nxt;
            STORE_FAULT <= pop & DMEM_RESP_ERR;
            if (pop & DMEM_RESP_ERR)
                STORE_FAULT_ADDR <= ADDR_W'({ent[head].waddr, 2'b00});
            if (push) begin
                vld[tail] <= 1'b1;
                tail      <= tail + PTR_W'(1);
            end
            if (pop) begin
                vld[head] <= 1'b0;
                head      <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // At most one write outstanding; head stays put until its ack.
    always_comb begin
        state_nxt = state;
        case (state)
            SB_IDLE:     if (count != '0) state_nxt = SB_ISSUE;
            SB_ISSUE:    if (DMEM_REQ_READY) state_nxt = SB_WAIT_ACK;
            SB_WAIT_ACK: if (DMEM_RESP_VALID)
                             state_nxt = (count > CNT_W'(1)) ? SB_ISSUE : SB_IDLE;
            default:     state_nxt = SB_IDLE;
        endcase
    end

    assign DMEM_REQ_VALID = issue;
    assign DMEM_REQ_ADDR  = issue ? ADDR_W'({ent[head].waddr, 2'b00}) : '0;
    assign DMEM_REQ_WMASK = issue ? ent[head].wmask : 4'h0;
    assign DMEM_REQ_WDATA = issue ? ent[head].wdata : 32'h0;

    // In-flight head is still valid here, so it is covered too.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (vld[i] && (ent[i].waddr == ld_waddr))
                hz = 1'b1;
    end

    assign LD_HAZARD = LD_CHECK_VALID & hz;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: latency, backpressure, hazards, faults, reset.
module tb_store_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ST_VALID;
    logic [31:0] ST_ADDR;
    logic [3:0]  ST_WMASK;
    logic [31:0] ST_WDATA;
    logic        ST_READY;
    logic        LD_CHECK_VALID;
    logic [31:0] LD_CHECK_ADDR;
    logic        LD_HAZARD;
    logic        DRAINED;
    logic        DMEM_REQ_VALID;
    logic        DMEM_REQ_READY;
    logic [31:0] DMEM_REQ_ADDR;
    logic [3:0]  DMEM_REQ_WMASK;
    logic [31:0] DMEM_REQ_WDATA;
    logic        DMEM_RESP_VALID;
    logic        DMEM_RESP_ERR;
    logic        STORE_FAULT;
    logic [31:0] STORE_FAULT_ADDR;

    store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .ST_VALID(ST_VALID), .ST_ADDR(ST_ADDR), .ST_WMASK(ST_WMASK), .ST_WDATA(ST_WDATA),
        .ST_READY(ST_READY),
        .LD_CHECK_VALID(LD_CHECK_VALID), .LD_CHECK_ADDR(LD_CHECK_ADDR), .LD_HAZARD(LD_HAZARD),
        .DRAINED(DRAINED),
        .DMEM_REQ_VALID(DMEM_REQ_VALID), .DMEM_REQ_READY(DMEM_REQ_READY),
        .DMEM_REQ_ADDR(DMEM_REQ_ADDR), .DMEM_REQ_WMASK(DMEM_REQ_WMASK),
        .DMEM_REQ_WDATA(DMEM_REQ_WDATA),
        .DMEM_RESP_VALID(DMEM_RESP_VALID), .DMEM_RESP_ERR(DMEM_RESP_ERR),
        .STORE_FAULT(STORE_FAULT), .STORE_FAULT_ADDR(STORE_FAULT_ADDR)
    );

    always #5 CLK = ~CLK;

    int n_tot  = 0;
    int n_pass = 0;

    logic [31:0] eq_addr[$];
    logic [31:0] eq_data[$];
    logic [3:0]  eq_mask[$];
    bit          eq_err[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] d, input bit e);
        eq_addr.push_back(a); eq_mask.push_back(m);
        eq_data.push_back(d); eq_err.push_back(e);
    endtask

    task automatic push(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        cyc();
        ST_VALID = 1'b1; ST_ADDR = a; ST_WMASK = m; ST_WDATA = d;
        #1;
        chk("push_rdy", ST_READY, 1);
        cyc();
        ST_VALID = 1'b0;
    endtask

    // Memory model: accepts every request, acks one cycle later with the queued error flag.
    task automatic drain(input int n);
        int          got;
        bit          hs, resp, fault_due, st_acc, done;
        logic        hs_err, resp_err, f_err;
        logic [31:0] hs_addr, resp_addr, f_addr;
        got = 0; hs = 0; resp = 0; st_acc = 0; done = 0;
        hs_err = 0; resp_err = 0; hs_addr = '0; resp_addr = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            cyc();
            DMEM_REQ_READY = 1'b1;
            fault_due = resp; f_err = resp_err; f_addr = resp_addr;
            resp = hs; resp_err = hs_err; resp_addr = hs_addr;
            DMEM_RESP_VALID = resp;
            DMEM_RESP_ERR   = resp & resp_err;
            if (st_acc) ST_VALID = 1'b0;
            #1;
            if (fault_due) begin
                chk("fault_pulse", STORE_FAULT, f_err);
                if (f_err) chk("fault_addr", STORE_FAULT_ADDR, f_addr);
            end
            hs = 0;
            if (DMEM_REQ_VALID) begin
                if (got < n) begin
                    chk("req_addr",  DMEM_REQ_ADDR,  eq_addr[got]);
                    chk("req_wmask", DMEM_REQ_WMASK, eq_mask[got]);
                    chk("req_wdata", DMEM_REQ_WDATA, eq_data[got]);
                    hs_err = eq_err[got]; hs_addr = eq_addr[got];
                    got++;
                end else begin
                    chk("extra_req", DMEM_REQ_VALID, 0);
                end
                hs = 1;
            end
            st_acc = ST_VALID && ST_READY;
            if (got == n && !hs && !resp && DRAINED && !ST_VALID) done = 1;
        end
        chk("drain_cnt", got, n);
        chk("drain_done", DRAINED, 1);
        DMEM_RESP_VALID = 0; DMEM_RESP_ERR = 0; DMEM_REQ_READY = 0;
        eq_addr.delete(); eq_mask.delete(); eq_data.delete(); eq_err.delete();
    endtask

    initial begin
        RST = 1; ST_VALID = 0; ST_ADDR = 0; ST_WMASK = 0; ST_WDATA = 0;
        LD_CHECK_VALID = 0; LD_CHECK_ADDR = 0;
        DMEM_REQ_READY = 0; DMEM_RESP_VALID = 0; DMEM_RESP_ERR = 0;
        #3;
        chk("rst_st_ready", ST_READY, 1);
        chk("rst_drained",  DRAINED, 1);
        chk("rst_req_vld",  DMEM_REQ_VALID, 0);
        chk("rst_fault",    STORE_FAULT, 0);
        chk("rst_hazard",   LD_HAZARD, 0);
        cyc(); cyc();
        RST = 0;

        // 1) single store latency N+2, ack pops
        cyc();
        ST_VALID = 1; ST_ADDR = 32'h100; ST_WMASK = 4'hF; ST_WDATA = 32'hDEADBEEF;
        DMEM_REQ_READY = 1;
        #1;
        chk("t1_rdy", ST_READY, 1);
        cyc();
        ST_VALID = 0;
        #1;
        chk("t1_n1_vld", DMEM_REQ_VALID, 0);
        chk("t1_n1_drained", DRAINED, 0);
        cyc();
        chk("t1_n2_vld",   DMEM_REQ_VALID, 1);
        chk("t1_n2_addr",  DMEM_REQ_ADDR, 32'h100);
        chk("t1_n2_wmask", DMEM_REQ_WMASK, 4'hF);
        chk("t1_n2_wdata", DMEM_REQ_WDATA, 32'hDEADBEEF);
        cyc();
        chk("t1_wait_vld", DMEM_REQ_VALID, 0);
        DMEM_RESP_VALID = 1;
        cyc();
        DMEM_RESP_VALID = 0; DMEM_REQ_READY = 0;
        #1;
        chk("t1_drained", DRAINED, 1);
        chk("t1_fault", STORE_FAULT, 0);

        // 2) five stores under backpressure, then in-order drain
        for (int k = 0; k < 5; k++) begin
            cyc();
            ST_VALID = 1; ST_ADDR = 32'h300 + 32'(4 * k); ST_WMASK = 4'hF;
            ST_WDATA = 32'hA0 + 32'(k);
            expect_wr(32'h300 + 32'(4 * k), 4'hF, 32'hA0 + 32'(k), 0);
            #1;
            if (k < 4) chk("t2_rdy", ST_READY, 1);
            else       chk("t2_full", ST_READY, 0);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("t2_hold_rdy",  ST_READY, 0);
            chk("t2_hold_vld",  DMEM_REQ_VALID, 1);
            chk("t2_hold_addr", DMEM_REQ_ADDR, 32'h300);
        end
        drain(5);

        // 3) load hazard on buffered byte store
        cyc();
        ST_VALID = 1; ST_ADDR = 32'h203; ST_WMASK = 4'h8; ST_WDATA = 32'hAB000000;
        LD_CHECK_VALID = 1; LD_CHECK_ADDR = 32'h200;
        #1;
        chk("t3_same_cycle", LD_HAZARD, 0);
        cyc();
        ST_VALID = 0;
        #1;
        chk("t3_hit", LD_HAZARD, 1);
        LD_CHECK_ADDR = 32'h204;
        #1;
        chk("t3_next_word", LD_HAZARD, 0);
        LD_CHECK_ADDR = 32'h200; LD_CHECK_VALID = 0;
        #1;
        chk("t3_not_valid", LD_HAZARD, 0);
        LD_CHECK_VALID = 1;
        expect_wr(32'h200, 4'h8, 32'hAB000000, 0);
        drain(1);
        chk("t3_after_ack", LD_HAZARD, 0);
        LD_CHECK_VALID = 0;

        // 4) zero mask: accepted but not queued
        cyc();
        ST_VALID = 1; ST_ADDR = 32'h400; ST_WMASK = 4'h0; ST_WDATA = 32'h12345678;
        #1;
        chk("t4_rdy", ST_READY, 1);
        cyc();
        ST_VALID = 0;
        #1;
        chk("t4_drained", DRAINED, 1);
        cyc(); cyc();
        chk("t4_no_req", DMEM_REQ_VALID, 0);

        // 5) bus error on first of two writes
        push(32'h40, 4'hF, 32'h1);
        push(32'h44, 4'hF, 32'h2);
        expect_wr(32'h40, 4'hF, 32'h1, 1);
        expect_wr(32'h44, 4'hF, 32'h2, 0);
        drain(2);

        // 6) reset during WAIT_ACK with 3 entries, then a stale ack
        push(32'h600, 4'hF, 32'h6);
        push(32'h604, 4'hF, 32'h7);
        push(32'h608, 4'hF, 32'h8);
        cyc();
        DMEM_REQ_READY = 1;
        #1;
        chk("t6_issue", DMEM_REQ_VALID, 1);
        cyc();
        DMEM_REQ_READY = 0;
        LD_CHECK_VALID = 1; LD_CHECK_ADDR = 32'h600;
        #1;
        chk("t6_wait_vld", DMEM_REQ_VALID, 0);
        chk("t6_inflight_hz", LD_HAZARD, 1);
        chk("t6_busy", DRAINED, 0);
        #1;
        RST = 1;
        #1;
        chk("t6_rst_drained", DRAINED, 1);
        chk("t6_rst_hz", LD_HAZARD, 0);
        chk("t6_rst_rdy", ST_READY, 1);
        cyc();
        RST = 0;
        cyc();
        DMEM_RESP_VALID = 1; DMEM_RESP_ERR = 1;
        cyc();
        DMEM_RESP_VALID = 0; DMEM_RESP_ERR = 0;
        #1;
        chk("t6_stale_fault", STORE_FAULT, 0);
        chk("t6_stale_drained", DRAINED, 1);
        cyc();
        chk("t6_stale_req", DMEM_REQ_VALID, 0);
        LD_CHECK_VALID = 0;

        // reset while a request is on the bus drops VALID at once
        push(32'h700, 4'h3, 32'h9);
        cyc(); cyc();
        chk("t6b_issue", DMEM_REQ_VALID, 1);
        RST = 1;
        #1;
        chk("t6b_rst_vld",  DMEM_REQ_VALID, 0);
        chk("t6b_rst_addr", DMEM_REQ_ADDR, 0);
        cyc();
        RST = 0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
